// File: rtl/immobilizer_seq_ctrl.sv
// Immobilizer sequencer: secret keypad code entry with per-symbol timeout, attempt
// budget and timed alarm lockout, gating the fuel pump relay enable.
module immobilizer_seq_ctrl #(
  parameter int                          SYM_W          = 2,
  parameter int                          CODE_LEN       = 4,
  parameter logic [CODE_LEN*SYM_W-1:0]   SECRET         = 8'hE4,
  parameter int                          ENTRY_TIMEOUT  = 1000,
  parameter int                          MAX_ATTEMPTS   = 3,
  parameter int                          LOCKOUT_CYCLES = 5000,
  localparam int                         ATT_W          = $clog2(MAX_ATTEMPTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ignition_on,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym,
  input  logic             brake_pressed,
  output logic             pump_enable,
  output logic             alarm,
  output logic             locked_out,
  output logic [ATT_W-1:0] attempts_left,
  output logic [2:0]       state_dbg
);

  localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int ET_W  = $clog2(ENTRY_TIMEOUT + 1);
  localparam int LT_W  = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CODE_LEN - 1);
  localparam logic [ET_W-1:0]  ENT_LOAD  = ET_W'(ENTRY_TIMEOUT);
  localparam logic [LT_W-1:0]  LOCK_LOAD = LT_W'(LOCKOUT_CYCLES);
  localparam logic [ATT_W-1:0] ATT_FULL  = ATT_W'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_ARMED   = 3'd2,
    S_RUN     = 3'd3,
    S_LOCKOUT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mism_q, mism_d;
  logic [ET_W-1:0]  ent_tmr_q, ent_tmr_d;
  logic [LT_W-1:0]  lock_tmr_q, lock_tmr_d;
  logic [ATT_W-1:0] att_q, att_d;

  logic [SYM_W-1:0] exp_sym;
  logic             mism_now;
  logic             fail;
  logic [ATT_W-1:0] att_dec;

  always_comb begin
    exp_sym = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IDX_W'(i)) exp_sym = SECRET[i*SYM_W +: SYM_W];
    end
  end

  assign mism_now = mism_q | (sym != exp_sym);
  assign att_dec  = (att_q != '0) ? (att_q - ATT_W'(1)) : '0;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mism_d     = mism_q;
    ent_tmr_d  = ent_tmr_q;
    lock_tmr_d = lock_tmr_q;
    att_d      = att_q;
    fail       = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d  = '0;
        mism_d = 1'b0;
        if (ignition_on) begin
          state_d   = S_ENTRY;
          ent_tmr_d = ENT_LOAD;
        end
      end

      S_ENTRY: begin
        // Ignition drop outranks any symbol or expiry arriving in the same cycle.
        if (!ignition_on) begin
          state_d   = S_IDLE;
          idx_d     = '0;
          mism_d    = 1'b0;
          ent_tmr_d = '0;
        end else if (sym_valid) begin
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            mism_d = 1'b0;
            if (!mism_now) begin
              state_d   = S_ARMED;
              att_d     = ATT_FULL;
              ent_tmr_d = '0;
            end else begin
              fail = 1'b1;
            end
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            mism_d    = mism_now;
            ent_tmr_d = ENT_LOAD;
          end
        end else if (ent_tmr_q <= ET_W'(1)) begin
          fail = 1'b1;
        end else begin
          ent_tmr_d = ent_tmr_q - ET_W'(1);
        end
      end

      S_ARMED: begin
        if (!ignition_on) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (brake_pressed) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (!ignition_on) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end

      S_LOCKOUT: begin
        if (lock_tmr_q <= LT_W'(1)) begin
          state_d    = S_IDLE;
          att_d      = ATT_FULL;
          lock_tmr_d = '0;
        end else begin
          lock_tmr_d = lock_tmr_q - LT_W'(1);
        end
      end

      default: begin
        state_d    = S_IDLE;
        idx_d      = '0;
        mism_d     = 1'b0;
        ent_tmr_d  = '0;
        lock_tmr_d = '0;
      end
    endcase

    // A failed entry restarts the code from scratch unless the budget is spent.
    if (fail) begin
      idx_d     = '0;
      mism_d    = 1'b0;
      att_d     = att_dec;
      ent_tmr_d = ENT_LOAD;
      if (att_dec == '0) begin
        state_d    = S_LOCKOUT;
        lock_tmr_d = LOCK_LOAD;
        ent_tmr_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      mism_q     <= 1'b0;
      ent_tmr_q  <= '0;
      lock_tmr_q <= '0;
      att_q      <= ATT_FULL;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mism_q     <= mism_d;
      ent_tmr_q  <= ent_tmr_d;
      lock_tmr_q <= lock_tmr_d;
      att_q      <= att_d;
    end
  end

  assign pump_enable   = (state_q == S_RUN);
  assign alarm         = (state_q == S_LOCKOUT);
  assign locked_out    = (state_q == S_LOCKOUT);
  assign attempts_left = att_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_immobilizer_seq_ctrl.sv
// Bench for immobilizer_seq_ctrl: cycle model built on a symbol queue and elapsed-cycle
// counts, compared every cycle, plus directed scenarios with literal expectations.
module tb_immobilizer_seq_ctrl;

  localparam int CL   = 4;
  localparam int TO   = 1000;
  localparam int LOCK = 5000;
  localparam int MAXA = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ignition_on = 1'b0;
  logic       sym_valid = 1'b0;
  logic [1:0] sym = 2'd0;
  logic       brake_pressed = 1'b0;
  logic       pump_enable;
  logic       alarm;
  logic       locked_out;
  logic [1:0] attempts_left;
  logic [2:0] state_dbg;

  immobilizer_seq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .ignition_on   (ignition_on),
    .sym_valid     (sym_valid),
    .sym           (sym),
    .brake_pressed (brake_pressed),
    .pump_enable   (pump_enable),
    .alarm         (alarm),
    .locked_out    (locked_out),
    .attempts_left (attempts_left),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: 0=IDLE 1=ENTRY 2=ARMED 3=RUN 4=LOCKOUT
  int secret_syms [CL] = '{0, 1, 2, 3};
  int m_state = 0;
  int m_att = MAXA;
  int m_q[$];
  int m_wait = 0;
  int m_lock = 0;

  function automatic bit code_ok();
    for (int i = 0; i < CL; i++) if (m_q[i] != secret_syms[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit fail;
    fail = 1'b0;
    if (rst) begin
      m_state = 0; m_att = MAXA; m_q.delete(); m_wait = 0; m_lock = 0;
    end else begin
      case (m_state)
        0: begin
          m_q.delete();
          if (ignition_on) begin m_state = 1; m_wait = 0; end
        end
        1: begin
          if (!ignition_on) begin
            m_state = 0; m_q.delete();
          end else if (sym_valid) begin
            m_q.push_back(int'(sym));
            m_wait = 0;
            if (m_q.size() == CL) begin
              if (code_ok()) begin m_state = 2; m_att = MAXA; end
              else fail = 1'b1;
              m_q.delete();
            end
          end else begin
            m_wait++;
            if (m_wait >= TO) fail = 1'b1;
          end
          if (fail) begin
            m_att--; m_q.delete(); m_wait = 0;
            if (m_att == 0) begin m_state = 4; m_lock = 0; end
          end
        end
        2: if (!ignition_on) m_state = 0; else if (brake_pressed) m_state = 3;
        3: if (!ignition_on) m_state = 0;
        default: begin
          m_lock++;
          if (m_lock >= LOCK) begin m_state = 0; m_att = MAXA; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_state", int'(state_dbg), m_state);
      chk("cyc_pump", int'(pump_enable), int'(m_state == 3));
      chk("cyc_alarm", int'(alarm), int'(m_state == 4));
      chk("cyc_locked", int'(locked_out), int'(m_state == 4));
      chk("cyc_attempts", int'(attempts_left), m_att);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_sym(input int s);
    sym_valid = 1'b1;
    sym = 2'(s);
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic send_code(input int a, input int b, input int c, input int d);
    send_sym(a); send_sym(b); send_sym(c); send_sym(d);
  endtask

  task automatic pulse_rst(input string tag);
    ignition_on = 1'b0;
    brake_pressed = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk({tag, "_pump"}, int'(pump_enable), 0);
    chk({tag, "_alarm"}, int'(alarm), 0);
    chk({tag, "_locked"}, int'(locked_out), 0);
    chk({tag, "_att"}, int'(attempts_left), 3);
    chk({tag, "_state"}, int'(state_dbg), 0);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    tick(2);
    chk("rst_state", int'(state_dbg), 0);
    chk("rst_pump", int'(pump_enable), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_att", int'(attempts_left), 3);
    rst = 1'b0;

    // Correct code, brake, ignition off
    ignition_on = 1'b1; tick(1);
    chk("t1_entry", int'(state_dbg), 1);
    send_code(0, 1, 2, 3);
    chk("t1_armed", int'(state_dbg), 2);
    chk("t1_pump_armed", int'(pump_enable), 0);
    brake_pressed = 1'b1; tick(1);
    chk("t1_pump_on", int'(pump_enable), 1);
    ignition_on = 1'b0; tick(1);
    chk("t1_pump_off", int'(pump_enable), 0);
    chk("t1_idle", int'(state_dbg), 0);
    brake_pressed = 1'b0;

    // One wrong code then the right one
    ignition_on = 1'b1; tick(1);
    send_code(0, 1, 3, 3);
    chk("t2_att", int'(attempts_left), 2);
    chk("t2_entry", int'(state_dbg), 1);
    send_code(0, 1, 2, 3);
    chk("t2_armed", int'(state_dbg), 2);
    chk("t2_att_reload", int'(attempts_left), 3);
    ignition_on = 1'b0; tick(1);

    // Three wrong codes -> lockout, inputs ignored meanwhile
    ignition_on = 1'b1; tick(1);
    send_code(3, 3, 3, 3);
    send_code(1, 0, 2, 3);
    send_code(0, 1, 2, 0);
    chk("t3_state", int'(state_dbg), 4);
    chk("t3_alarm", int'(alarm), 1);
    chk("t3_att", int'(attempts_left), 0);
    n = 0;
    while (state_dbg == 3'd4 && n < LOCK + 1000) begin
      ignition_on = (n < 30) ? n[1] : 1'b0;
      sym_valid = (n < 20) ? n[0] : 1'b0;
      sym = 2'(n);
      brake_pressed = (n < 10);
      @(negedge clk);
      n++;
    end
    sym_valid = 1'b0; brake_pressed = 1'b0; ignition_on = 1'b0;
    chk("t3_lock_len", n, LOCK);
    chk("t3_idle", int'(state_dbg), 0);
    chk("t3_att_reload", int'(attempts_left), 3);
    chk("t3_alarm_off", int'(alarm), 0);

    // Timeout, then a symbol coincident with expiry
    ignition_on = 1'b1; tick(1);
    tick(TO - 1);
    chk("t4_pre_to_att", int'(attempts_left), 3);
    tick(1);
    chk("t4_to_att", int'(attempts_left), 2);
    chk("t4_to_entry", int'(state_dbg), 1);
    tick(TO - 1);
    send_sym(0);
    chk("t4_edge_att", int'(attempts_left), 2);
    send_sym(1); send_sym(2); send_sym(3);
    chk("t4_edge_armed", int'(state_dbg), 2);
    ignition_on = 1'b0; tick(1);

    // Key cycling keeps the budget; final symbol with ignition drop
    ignition_on = 1'b1; tick(1);
    send_code(2, 2, 2, 2);
    chk("t5_att", int'(attempts_left), 2);
    ignition_on = 1'b0; tick(1);
    ignition_on = 1'b1; tick(1);
    chk("t5_att_kept", int'(attempts_left), 2);
    send_sym(0); send_sym(1); send_sym(2);
    sym_valid = 1'b1; sym = 2'd3; ignition_on = 1'b0;
    tick(1);
    sym_valid = 1'b0;
    chk("t5_drop_idle", int'(state_dbg), 0);
    chk("t5_drop_att", int'(attempts_left), 2);
    tick(3);
    chk("t5_pump_never", int'(pump_enable), 0);

    // Asynchronous reset in ENTRY, RUN and LOCKOUT
    ignition_on = 1'b1; tick(1);
    send_sym(0);
    pulse_rst("t6_entry");
    ignition_on = 1'b1; tick(1);
    send_code(0, 1, 2, 3);
    brake_pressed = 1'b1; tick(1);
    chk("t6_run_pump", int'(pump_enable), 1);
    pulse_rst("t6_run");
    ignition_on = 1'b1; tick(1);
    send_code(1, 1, 1, 1);
    send_code(1, 1, 1, 1);
    send_code(1, 1, 1, 1);
    tick(5);
    chk("t6_lock_alarm", int'(alarm), 1);
    pulse_rst("t6_lock");
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
